db_arbiter: RTL
===============

Name: db_arbiter

Overview:
- Shares the single CPU data-break (DMA) channel between up to four peripheral DMA masters, e.g. the RK8E disk controller and a future second mass-storage or serial DMA device.
- Performs round-robin arbitration and sequences each one-word break cycle against the CPU major state (DB1/DB2).
- Returns read data and a completion or error pulse to the owning requester.
- Sits between the peripheral DMA ports and the CPU `data_break` / `dmaAddr` / `to_disk` inputs.

Parameters:
- NREQ, 2, number of requesters (1..4).
- DB1_CODE, 5'd0, CPU `state` encoding of DB1; must be overridden with the CPU's DB1 constant at instantiation.
- DB2_CODE, 5'd1, CPU `state` encoding of DB2; must be overridden likewise.
- TIMEOUT, 1023, cycles to wait for DB1 before abandoning a request (10-bit counter).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  IOCLR; same effect as reset.
- state  in  5  CPU major state.
- break_in_prog  in  1  CPU is servicing a break from an unarbitrated source.
- req  in  NREQ  per-requester break request; level, held until done/err/cancel.
- rd_mem  in  NREQ  per requester: 1 = memory-to-device (read), 0 = device-to-memory (write).
- addr  in  15*NREQ  per-requester 15-bit memory address; requester i occupies bits [15i+14:15i].
- wdata  in  12*NREQ  per-requester write data; requester i occupies bits [12i+11:12i].
- grant  out  NREQ  one-hot owner of the channel.
- done  out  NREQ  one-cycle completion pulse to the owner.
- err  out  NREQ  one-cycle timeout pulse to the owner.
- rdata  out  12  memory read data; valid in the cycle `done` is high.
- data_break  out  1  break request to the CPU.
- to_disk  out  1  copy of the owner's `rd_mem`.
- dmaAddr  out  15  address to the CPU.
- dmaDOUT  out  12  write data to memory.
- dmaDIN  in  12  read data from memory.

Behaviour:
- Reset/clear:
  - FSM goes to IDLE; round-robin pointer = 0.
  - `grant`, `done`, `err`, `data_break`, `to_disk`, `dmaAddr`, `dmaDOUT`, `rdata` and the timeout counter all go to 0.
  - Reset or clear asserted in any state aborts the cycle with no `done`/`err`.
- FSM states: IDLE, ARB, REQ, XFER.
- IDLE:
  - If any `req` bit is set and `break_in_prog` = 0, go to ARB.
  - While `break_in_prog` = 1, stay in IDLE.
- ARB (1 cycle):
  - Select the first set `req` bit starting at the pointer and wrapping modulo NREQ.
  - Set its `grant` bit.
  - Latch its `addr`→`dmaAddr`, `wdata`→`dmaDOUT`, `rd_mem`→`to_disk`.
  - Clear the timeout counter and go to REQ.
  - If the `req` bits have all dropped, return to IDLE with no grant.
- REQ:
  - `data_break` = 1 and the counter increments each cycle.
  - If `state` == DB1_CODE: `data_break` goes to 0 next cycle; go to XFER.
  - If the owner drops `req` before DB1 (cancel): go to IDLE, `grant` = 0, no pulse, pointer unchanged.
  - If the counter reaches TIMEOUT: pulse the owner's `err`, drop `grant` and `data_break`, advance the pointer to owner+1, go to IDLE.
  - DB1 arriving in the same cycle as a cancel or a timeout takes priority (go to XFER).
- XFER:
  - Wait for `state` == DB2_CODE.
  - On that cycle: if `to_disk` = 1, capture `dmaDIN`→`rdata`; pulse `done` for the owner next cycle.
  - Then clear `grant`, set pointer = owner+1 mod NREQ, go to IDLE.
  - Once DB1 is seen, `req` changes are ignored; the transfer always completes.
- Latched `dmaAddr`, `dmaDOUT` and `to_disk` stay stable from ARB until return to IDLE. They retain their last value afterwards.
- Throughput: minimum turnaround is one idle cycle between consecutive grants.
- `grant` is at most one-hot at all times. `done` and `err` are never asserted together.
- Requests are masked only by FSM occupancy; a requester holding `req` after `done` is re-arbitrated and gets a new word.

Test Plan:
- Single requester 0, `rd_mem`=0, `addr`=15'o01234, `wdata`=12'o5555; CPU model asserts DB1 3 cycles after `data_break`, DB2 next cycle → `dmaAddr`=01234, `dmaDOUT`=5555, `to_disk`=0, `done[0]` one pulse, `grant` returns to 0.
- Read: requester 1, `rd_mem`=1, `dmaDIN`=12'o7070 during DB2 → `to_disk`=1, `rdata`=7070 in the cycle `done[1]`=1.
- Both requesters holding `req` continuously for 4 transfers → grant order 0,1,0,1; never two grant bits set.
- No DB1 ever → `err` pulse exactly 1023 cycles after REQ entry; `data_break` drops; pointer advanced so the other requester is served next.
- Cancel: drop `req[0]` while in REQ before DB1 → IDLE, no `done`/`err`. Drop `req[0]` after DB1 → `done[0]` still pulses.
- Assert `clear` during XFER → all outputs 0 next cycle, no `done`. Hold `break_in_prog`=1 with `req` set → `data_break` stays 0 until it is released.

Source files
------------

// File: rtl/db_arbiter_if.sv
// db_arbiter_if: peripheral DMA ports and CPU data-break signals of the arbiter
interface db_arbiter_if #(
  parameter int NREQ = 2
);
  logic [4:0]         state;
  logic               break_in_prog;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    rd_mem;
  logic [15*NREQ-1:0] addr;
  logic [12*NREQ-1:0] wdata;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [11:0]        rdata;
  logic               data_break;
  logic               to_disk;
  logic [14:0]        dmaAddr;
  logic [11:0]        dmaDOUT;
  logic [11:0]        dmaDIN;
  modport slave (
    input  state, break_in_prog, req, rd_mem, addr, wdata, dmaDIN,
    output grant, done, err, rdata, data_break, to_disk, dmaAddr, dmaDOUT
  );
  modport master (
    output state, break_in_prog, req, rd_mem, addr, wdata, dmaDIN,
    input  grant, done, err, rdata, data_break, to_disk, dmaAddr, dmaDOUT
  );
endinterface

// File: rtl/db_arbiter.sv
// db_arbiter: round-robin sharing of the CPU data-break channel among NREQ DMA masters
module db_arbiter #(
  parameter int         NREQ     = 2,
  parameter logic [4:0] DB1_CODE = 5'd0,
  parameter logic [4:0] DB2_CODE = 5'd1,
  parameter int         TIMEOUT  = 1023
) (
  input logic         clk,
  input logic         reset,
  input logic         clear,
  db_arbiter_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, ARB, REQ, XFER} state_t;
  state_t cur, nxt;
  logic [IW-1:0] ptr, owner, sel, owner_inc;
  logic [NREQ-1:0] rot, grant, done, err;
  logic [9:0] cnt;
  logic [14:0] dma_addr;
  logic [11:0] dma_dout, rdata;
  logic data_break, to_disk, db1, db2, owner_req, timeout;
  assign db1 = bus.state == DB1_CODE;
  assign db2 = bus.state == DB2_CODE;
  assign owner_req = bus.req[owner];
  assign timeout = cnt == 10'(TIMEOUT - 1);
  assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign rot = NREQ'({bus.req, bus.req} >> ptr);
  assign bus.grant = grant;
  assign bus.done = done;
  assign bus.err = err;
  assign bus.rdata = rdata;
  assign bus.data_break = data_break;
  assign bus.to_disk = to_disk;
  assign bus.dmaAddr = dma_addr;
  assign bus.dmaDOUT = dma_dout;
  // first requesting index at or after the pointer, wrapping; lowest offset wins
  always_comb begin
    sel = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) sel = IW'((int'(ptr) + i) % NREQ);
  end
  // next state; DB1 outranks both cancel and timeout while requesting
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = (|bus.req && !bus.break_in_prog) ? ARB : IDLE;
      ARB:     nxt = |bus.req ? REQ : IDLE;
      REQ:     nxt = db1 ? XFER : (!owner_req || timeout) ? IDLE : REQ;
      XFER:    nxt = db2 ? IDLE : XFER;
      default: nxt = IDLE;
    endcase
  end
  // state register; clear aborts any cycle exactly like reset
  always_ff @(posedge clk) begin
    if (reset || clear) cur <= IDLE;
    else cur <= nxt;
  end
  // grant, latched break parameters, timeout counter and owner pulses
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
      owner <= '0;
      grant <= '0;
      done <= '0;
      err <= '0;
      data_break <= 1'b0;
      to_disk <= 1'b0;
      dma_addr <= '0;
      dma_dout <= '0;
      rdata <= '0;
      cnt <= '0;
    end else begin
      done <= '0;
      err <= '0;
      if (cur == ARB && |bus.req) begin
        owner <= sel;
        grant <= NREQ'(1) << sel;
        data_break <= 1'b1;
        to_disk <= bus.rd_mem[sel];
        dma_addr <= 15'(bus.addr >> (15 * sel));
        dma_dout <= 12'(bus.wdata >> (12 * sel));
        cnt <= '0;
      end
      if (cur == REQ) begin
        cnt <= cnt + 1'b1;
        if (db1 || !owner_req || timeout) data_break <= 1'b0;
        if (!db1 && !owner_req) grant <= '0;
        else if (!db1 && timeout) begin
          grant <= '0;
          err[owner] <= 1'b1;
          ptr <= owner_inc;
        end
      end
      if (cur == XFER && db2) begin
        if (to_disk) rdata <= bus.dmaDIN;
        done[owner] <= 1'b1;
        grant <= '0;
        ptr <= owner_inc;
      end
    end
  end
endmodule
